// File: rtl/hue_fade_pwm_if.sv
// Control/observation bundle for hue_fade_pwm: run enable and fade rate in,
// PWM drive, per-channel duty and cycle-wrap pulse out.
interface hue_fade_pwm_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DW     = 11,
    parameter int unsigned RATE_W = 8
);
    logic                   en;
    logic [RATE_W-1:0]      rate;
    logic [NUM_CH-1:0]      led_out;
    logic [NUM_CH*DW-1:0]   duty;
    logic                   wrap;

    modport master (output en, rate, input led_out, duty, wrap);
    modport slave  (input en, rate, output led_out, duty, wrap);
endinterface

// File: rtl/hue_fade_pwm.sv
// Multi-channel hue-wheel fader: one shared PWM counter and segment/step sequencer,
// each channel reading the 6-segment fade profile at its own phase offset.
module hue_fade_pwm #(
    parameter int unsigned         NUM_CH       = 3,
    parameter int unsigned         PWM_INTERVAL = 1200,
    parameter int unsigned         SEG_STEPS    = 60,
    parameter int unsigned         RATE_W       = 8,
    parameter logic [3*NUM_CH-1:0] PHASE        = {3'd4, 3'd0, 3'd1},
    parameter bit                  ACTIVE_LOW   = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    hue_fade_pwm_if.slave  bus
);
    localparam int unsigned DW       = $clog2(PWM_INTERVAL + 1);
    localparam int unsigned SW       = (SEG_STEPS > 1) ? $clog2(SEG_STEPS) : 1;
    localparam int unsigned DUTY_INC = PWM_INTERVAL / SEG_STEPS;
    localparam logic [DW-1:0] CntLast  = DW'(PWM_INTERVAL - 1);
    localparam logic [DW-1:0] DutyFull = DW'(PWM_INTERVAL);
    localparam logic [SW-1:0] StepLast = SW'(SEG_STEPS - 1);

    logic [DW-1:0]     cnt_q, cnt_d;
    logic [RATE_W-1:0] div_q, div_d, rate_eff;
    logic [SW-1:0]     step_q, step_d;
    logic [2:0]        seg_q, seg_d;
    logic              wrap_q, wrap_d;
    logic [NUM_CH-1:0] led_q, led_d;
    logic [DW-1:0]     duty_q [NUM_CH];
    logic [DW-1:0]     target [NUM_CH];
    logic [3:0]        ph_sum [NUM_CH];
    logic [2:0]        ph_fld [NUM_CH];
    logic [DW-1:0]     ramp;
    logic              period_end;

    // Sequencer: advances only on period boundaries while enabled.
    always_comb begin
        period_end = (cnt_q == CntLast);
        cnt_d      = period_end ? '0 : cnt_q + DW'(1);
        rate_eff   = (bus.rate == '0) ? RATE_W'(1) : bus.rate;
        div_d      = div_q;
        step_d     = step_q;
        seg_d      = seg_q;
        wrap_d     = 1'b0;
        if (period_end && bus.en) begin
            if (div_q >= rate_eff - RATE_W'(1)) begin
                div_d = '0;
                if (step_q == StepLast) begin
                    step_d = '0;
                    seg_d  = (seg_q == 3'd5) ? 3'd0 : seg_q + 3'd1;
                    wrap_d = (seg_q == 3'd5);
                end else begin
                    step_d = step_q + SW'(1);
                end
            end else begin
                div_d = div_q + RATE_W'(1);
            end
        end
    end

    // Per-channel profile lookup; phase fields 6/7 fold back to 0/1.
    always_comb begin
        ramp = DW'(32'(step_q) * DUTY_INC);
        for (int k = 0; k < NUM_CH; k++) begin
            ph_fld[k] = PHASE[3*k +: 3];
            if (ph_fld[k] >= 3'd6) ph_fld[k] = ph_fld[k] - 3'd6;
            ph_sum[k] = {1'b0, seg_q} + {1'b0, ph_fld[k]};
            if (ph_sum[k] >= 4'd6) ph_sum[k] = ph_sum[k] - 4'd6;
            case (ph_sum[k][2:0])
                3'd0:       target[k] = ramp;
                3'd1, 3'd2: target[k] = DutyFull;
                3'd3:       target[k] = DutyFull - ramp;
                default:    target[k] = '0;
            endcase
            led_d[k] = (cnt_q < duty_q[k]) ^ ACTIVE_LOW;
            bus.duty[k*DW +: DW] = duty_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= '0;
            step_q <= '0;
            seg_q  <= '0;
            wrap_q <= 1'b0;
            led_q  <= {NUM_CH{ACTIVE_LOW}};
            for (int k = 0; k < NUM_CH; k++) duty_q[k] <= '0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            step_q <= step_d;
            seg_q  <= seg_d;
            wrap_q <= wrap_d;
            led_q  <= led_d;
            // Duty only reloads at the period boundary so a period never glitches.
            if (period_end) begin
                for (int k = 0; k < NUM_CH; k++) duty_q[k] <= target[k];
            end
        end
    end

    assign bus.led_out = led_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_hue_fade_pwm.sv
// Randomized self-checking bench for hue_fade_pwm against a fade-position reference model.
module tb_hue_fade_pwm;
    localparam int PI  = 8;
    localparam int SS  = 4;
    localparam int DI  = PI / SS;
    localparam int CYC = 6 * SS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hue_fade_pwm_if #(.NUM_CH(3), .DW(4), .RATE_W(8)) bus ();
    hue_fade_pwm_if #(.NUM_CH(3), .DW(4), .RATE_W(8)) bus7 ();
    assign bus7.en   = bus.en;
    assign bus7.rate = bus.rate;

    hue_fade_pwm #(.NUM_CH(3), .PWM_INTERVAL(PI), .SEG_STEPS(SS), .RATE_W(8),
                   .PHASE({3'd4, 3'd0, 3'd1}), .ACTIVE_LOW(1'b1))
        dut (.clk(clk), .rst(rst), .bus(bus));
    hue_fade_pwm #(.NUM_CH(3), .PWM_INTERVAL(PI), .SEG_STEPS(SS), .RATE_W(8),
                   .PHASE({3'd4, 3'd0, 3'd7}), .ACTIVE_LOW(1'b1))
        dut7 (.clk(clk), .rst(rst), .bus(bus7));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_wrap = -1;
    bit wrap_chk  = 1'b0;

    // Model: fade position counts step advances since the start of the 6-segment cycle.
    int m_cnt, m_div, m_pos;
    int m_duty[3];
    int m_duty7[3];
    logic [2:0] m_led;
    logic m_wrap;
    int ph_main[3] = '{1, 0, 4};
    int ph_7[3]    = '{7, 0, 4};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int target(input int phase, input int pos);
        int seg, st, p;
        seg = pos / SS;
        st  = pos % SS;
        p   = (seg + phase) % 6;
        if (p == 0) return st * DI;
        if (p == 1 || p == 2) return PI;
        if (p == 3) return PI - st * DI;
        return 0;
    endfunction

    function automatic logic [11:0] pack(input int d[3]);
        logic [11:0] v;
        for (int k = 0; k < 3; k++) v[k*4 +: 4] = 4'(d[k]);
        return v;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_div = 0; m_pos = 0; m_led = 3'b111; m_wrap = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_duty[k] = 0;
            m_duty7[k] = 0;
        end
    endtask

    task automatic model_update();
        int reff;
        reff = (bus.rate == 0) ? 1 : int'(bus.rate);
        for (int k = 0; k < 3; k++) m_led[k] = !(m_cnt < m_duty[k]);
        m_wrap = 1'b0;
        if (m_cnt == PI - 1) begin
            for (int k = 0; k < 3; k++) begin
                m_duty[k]  = target(ph_main[k], m_pos);
                m_duty7[k] = target(ph_7[k], m_pos);
            end
            if (bus.en) begin
                if (m_div >= reff - 1) begin
                    m_div = 0;
                    m_pos = m_pos + 1;
                    if (m_pos == CYC) begin
                        m_pos  = 0;
                        m_wrap = 1'b1;
                    end
                end else begin
                    m_div = m_div + 1;
                end
            end
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_update();
        #1;
        cyc++;
        check("duty", 32'(bus.duty), 32'(pack(m_duty)));
        check("led_out", 32'(bus.led_out), 32'(m_led));
        check("wrap", 32'(bus.wrap), 32'(m_wrap));
        check("duty_ph7", 32'(bus7.duty), 32'(pack(m_duty7)));
        if (bus.wrap) begin
            if (wrap_chk && last_wrap >= 0) check("wrap_period", cyc - last_wrap, 6 * SS * PI);
            last_wrap = cyc;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bus.en   = 1'b1;
        bus.rate = 8'd1;
        model_reset();
        ticks(3);
        rst = 1'b0;

        // Dark first period, seg0 load, seg2 load, then two wraps at rate 1.
        wrap_chk = 1'b1;
        ticks(8);
        check("load_seg0", 32'(bus.duty), 32'h008);
        ticks(64);
        check("load_seg2", 32'(bus.duty), 32'h088);
        ticks(400);
        wrap_chk = 1'b0;

        // Async reset mid-period takes effect without a clock edge.
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_led", 32'(bus.led_out), 32'h7);
        check("rst_duty", 32'(bus.duty), 32'h0);
        check("rst_wrap", 32'(bus.wrap), 32'h0);
        ticks(2);
        rst = 1'b0;
        ticks(20);

        bus.rate = 8'd3; ticks(200);
        bus.rate = 8'd0; ticks(200);

        // Rate drop while the divider is partway through its count.
        bus.rate = 8'd5;
        begin
            int guard = 0;
            while (m_div != 2 && guard < 400) begin
                tick();
                guard++;
            end
            check("div_reach2", 32'(m_div == 2), 32'd1);
        end
        bus.rate = 8'd1;
        ticks(40);

        // Freeze mid-segment for five periods, then resume.
        ticks(3);
        bus.en = 1'b0; ticks(5 * PI);
        bus.en = 1'b1; ticks(60);

        for (int r = 0; r < 24; r++) begin
            bus.en   = ($urandom_range(0, 3) != 0);
            bus.rate = 8'($urandom_range(0, 3));
            ticks($urandom_range(8, 120));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
